csa_resolve_40: RTL and testbench

//  Downstream of the 40-bit carry-save modular adder. Converts a redundant (carry, sum) pair into one canonical

---
 rtl/mod40_pkg.sv | 14 +
 rtl/csa_resolve_40_if.sv | 23 ++
 rtl/csa_resolve_40_cpa_slice.sv | 12 +
 rtl/csa_resolve_40.sv | 126 ++++++++++++
 tb/tb_csa_resolve_40.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod40_pkg.sv
// Shared constants and state encoding for the 40-bit modular datapath.
// add_40_lut uses the same P so the two blocks cannot drift apart.
package mod40_pkg;
  localparam int unsigned W         = 40;
  localparam int unsigned CHUNK     = 10;
  localparam int unsigned NSLICE    = W / CHUNK;
  localparam int unsigned RED_STEPS = 3;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned IDX_W     = 6;

  localparam logic [W:0] P_EXT = {1'b0, 40'h85bfc65fef};

  typedef enum logic [1:0] {IDLE, ADD, RED, DONE} state_t;
endpackage

// File: rtl/csa_resolve_40_if.sv
// Operand-in / residue-out handshake bundle for csa_resolve_40.
interface csa_resolve_40_if;
  import mod40_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] c_i;
  logic [W-1:0] s_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r_o;
  logic         busy;

  modport slave (
    input  in_valid, c_i, s_i, out_ready,
    output in_ready, out_valid, r_o, busy
  );

  modport master (
    output in_valid, c_i, s_i, out_ready,
    input  in_ready, out_valid, r_o, busy
  );
endinterface

// File: rtl/csa_resolve_40_cpa_slice.sv
// One CHUNK-bit ripple-carry slice, reused by csa_resolve_40 each ADD cycle.
module cpa_slice
  import mod40_pkg::*;
(
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(cin_i);
endmodule

// File: rtl/csa_resolve_40.sv
// Resolves a carry-save (c, s) pair into the canonical residue (c + s) mod P:
// W/CHUNK cycles of sliced carry-propagate add, then RED_STEPS conditional subtracts.
module csa_resolve_40
  import mod40_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  csa_resolve_40_if.slave bus
);
  state_t           state_q, state_d;
  logic [W-1:0]     c_q, c_d;
  logic [W-1:0]     s_q, s_d;
  logic [W:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     r_q, r_d;

  logic [IDX_W-1:0] base_c;
  logic [CHUNK-1:0] a_slice_c, b_slice_c, sum_slice_c;
  logic             cout_slice_c;
  logic [W+1:0]     sub_c;
  logic [W:0]       red_next_c;
  logic             accept_c;

  // Slice operand selection for the shared ripple adder
  assign base_c    = IDX_W'(cnt_q) * IDX_W'(CHUNK);
  assign a_slice_c = c_q[base_c +: CHUNK];
  assign b_slice_c = s_q[base_c +: CHUNK];

  cpa_slice u_cpa (
    .a_i    (a_slice_c),
    .b_i    (b_slice_c),
    .cin_i  (cin_q),
    .sum_o  (sum_slice_c),
    .cout_o (cout_slice_c)
  );

  // No borrow out of the W+1-bit subtract means acc >= P
  assign sub_c      = {1'b0, acc_q} - {1'b0, P_EXT};
  assign red_next_c = sub_c[W+1] ? acc_q : sub_c[W:0];

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ADD) || (state_q == RED);
  assign bus.r_o       = r_q;
  assign accept_c      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    s_d     = s_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    r_d     = r_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          c_d     = bus.c_i;
          s_d     = bus.s_i;
          acc_d   = '0;
          cnt_d   = '0;
          cin_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d[base_c +: CHUNK] = sum_slice_c;
        cin_d                  = cout_slice_c;
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          acc_d[W] = cout_slice_c;
          cnt_d    = '0;
          state_d  = RED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RED: begin
        acc_d = red_next_c;
        if (cnt_q == CNT_W'(RED_STEPS - 1)) begin
          r_d     = red_next_c[W-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (accept_c) begin
            c_d     = bus.c_i;
            s_d     = bus.s_i;
            acc_d   = '0;
            cnt_d   = '0;
            cin_d   = 1'b0;
            state_d = ADD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_csa_resolve_40.sv
// Self-checking bench for csa_resolve_40: vector table, hand-written corner
// sequences and a (c+s)%P scoreboard under random output stalls.
module tb_csa_resolve_40;
  localparam logic [39:0] PM   = 40'h85bfc65fef;
  localparam int          NRND = 2000;

  logic clk;
  logic rst_n;
  csa_resolve_40_if bus ();

  csa_resolve_40 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  logic [39:0] sb[$];

  typedef struct {
    logic [39:0] c;
    logic [39:0] s;
    logic [39:0] r;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] model(input logic [39:0] c, input logic [39:0] s);
    logic [40:0] t;
    t = {1'b0, c} + {1'b0, s};
    t = t % {1'b0, PM};
    return t[39:0];
  endfunction

  // Scoreboard: push on accepted operands, pop on consumed results
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 64'(bus.r_o), 64'hdead);
        end else begin
          check("sb_result", 64'(bus.r_o), 64'(sb.pop_front()));
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.c_i, bus.s_i));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present operands until accepted; returns #1 after the accepting edge
  task automatic send(input logic [39:0] c, input logic [39:0] s);
    int k;
    bus.in_valid = 1'b1;
    bus.c_i      = c;
    bus.s_i      = s;
    k            = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("send_timeout", 64'(k), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) to out_valid
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          start;
    int          cnt;
    logic [39:0] held;

    tbl[0] = '{40'h0,          40'h0,          40'h0};
    tbl[1] = '{40'h00000003ff, 40'h0000000001, 40'h0000000400};
    tbl[2] = '{PM,             40'h0,          40'h0};
    tbl[3] = '{PM - 40'd1,     40'h0,          40'h85bfc65fee};
    tbl[4] = '{40'hffffffffff, 40'hffffffffff, 40'h6ec0ace031};
    tbl[5] = '{40'hffffffffff, 40'h0,          40'h7a4039a010};
    tbl[6] = '{PM - 40'd1,     PM - 40'd1,     40'h85bfc65fed};
    tbl[7] = '{40'h1,          40'h1,          40'h2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.c_i       = '0;
    bus.s_i       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_r_o",       64'(bus.r_o),       64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].c, tbl[i].s);
      check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd1);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
      check($sformatf("vec%0d_r", i), 64'(bus.r_o), 64'(tbl[i].r));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_idle", i), 64'(bus.out_valid), 64'd0);
      check($sformatf("vec%0d_hold", i), 64'(bus.r_o), 64'(tbl[i].r));
    end

    // Output stall, then consume and accept in the same edge
    send(40'h1234567890, 40'hfedcba9876);
    wait_out(lat);
    held = bus.r_o;
    check("stall_r", 64'(held), 64'(model(40'h1234567890, 40'hfedcba9876)));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_r_stable", 64'(bus.r_o), 64'(held));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.c_i       = 40'h8000000000;
    bus.s_i       = 40'h7fffffffff;
    @(negedge clk);
    check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_out(lat);
    check("b2b_latency", 64'(lat), 64'd8);
    check("b2b_r", 64'(bus.r_o), 64'(model(40'h8000000000, 40'h7fffffffff)));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset during the second ADD cycle aborts the operation
    send(40'h00000fffff, 40'h0000000001);
    @(posedge clk);
    #1;
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) cnt++;
    end
    check("abort_no_output", 64'(cnt), 64'd0);
    send(40'h1, 40'h1);
    wait_out(lat);
    check("post_abort_latency", 64'(lat), 64'd8);
    check("post_abort_r", 64'(bus.r_o), 64'd2);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Random pairs under random consumer stalls
    start = n_out;
    fork
      begin
        for (int i = 0; i < NRND; i++) begin
          logic [39:0] rc, rs;
          rc = {8'($urandom), 32'($urandom)};
          rs = {8'($urandom), 32'($urandom)};
          if ($urandom_range(0, 15) == 0) rc = '1;
          if ($urandom_range(0, 15) == 0) rs = '1;
          send(rc, rs);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while ((n_out - start) < NRND && cyc < 60000) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        bus.out_ready = 1'b0;
      end
    join
    check("rnd_count", 64'(n_out - start), 64'(NRND));
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
